channel_dispatcher: RTL
=======================

Name: channel_dispatcher

Overview:
- Write-side front end for a bank of multi-CC channels. Accepts (pc, cc_id) tokens from an engine or result stage. Each token goes to one of CHANNEL_NUM channels: the ready channel with the lowest advertised wait latency.
- Ties are broken round-robin.
- Holds up to two tokens in a local skid buffer.
- Exports per-CC pending flags (channel-resident OR locally buffered), used for CC termination detection.

Parameters:
- PC_WIDTH, 8, program-counter bits per token.
- CC_ID_BITS, 2, character-context id bits; the id is in token bits [CC_ID_BITS-1:0] and pc is above it.
- LATENCY_COUNT_WIDTH, 10, width of each channel latency estimate.
- CHANNEL_NUM, 2, number of downstream channels (>=1).
- COUNT_WIDTH, 32, width of the dispatched-token counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted while 0.
- src_valid  in  1  upstream token valid.
- src_data  in  PC_WIDTH+CC_ID_BITS  upstream token.
- src_ready  out  1  buffer can accept a token.
- ch_valid  out  CHANNEL_NUM  one-hot dispatch strobe per channel.
- ch_data  out  CHANNEL_NUM*(PC_WIDTH+CC_ID_BITS)  head token, replicated into every slice.
- ch_ready  in  CHANNEL_NUM  channel input ready (not full).
- ch_latency  in  CHANNEL_NUM*LATENCY_COUNT_WIDTH  per-channel estimated wait, saturating.
- ch_present_cc_id  in  CHANNEL_NUM*2**CC_ID_BITS  per-channel CC presence flags.
- pending_cc_id  out  2**CC_ID_BITS  CC id k present in any channel or in the local buffer.
- dispatched_count  out  COUNT_WIDTH  total tokens dispatched, saturating.

Behaviour:
- Reset (rst=0, asynchronous), all state cleared:
  - buffer empty (count 0), rr_ptr=0, dispatched_count=0.
  - Hence src_ready=1, ch_valid=0, and pending_cc_id equals the OR of ch_present_cc_id only.
- Buffer: 2-entry FIFO, entries head and tail, occupancy count 0..2.
  - src_ready = (count != 2). It depends only on state, not on src_valid or ch_ready.
  - Push when src_valid && src_ready.
  - Pop when a dispatch handshake occurs.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - At count=2, no push is possible that cycle, even if a pop occurs.
- Eligibility: channel i is eligible iff ch_ready[i]=1 and count>0.
- Selection, combinational, within the same cycle:
  - sel = the eligible channel with the minimum ch_latency, compared as unsigned.
  - Ties: the first tied index at or after rr_ptr, scanning cyclically.
  - The all-ones (saturated) latency value compares normally, with no special case.
- Dispatch:
  - ch_valid[sel]=1 iff any channel is eligible; at most one bit of ch_valid is set.
  - ch_data carries the head token in every slice.
  - The transfer completes in the same cycle (ch_ready already qualifies it). Zero latency from buffer head to channel.
  - Channels must not derive ch_ready from ch_valid; the FIFO-full-based ready satisfies this.
- Latency from src push to earliest dispatch: 1 cycle. A token written at edge N can be dispatched in cycle N+1.
- Throughput: 1 token/cycle sustained while any channel is ready.
- rr_ptr: on each dispatch, rr_ptr <= (sel+1) mod CHANNEL_NUM. Otherwise it holds.
- No eligible channel: ch_valid=0, head held, rr_ptr held.
- dispatched_count increments by 1 per dispatch and saturates at all-ones.
- pending_cc_id[k] = (OR over i of ch_present_cc_id[i][k]) OR (any valid buffer entry has cc_id==k). Combinational.
- A token that is dispatched this cycle still counts as buffered this cycle. There is no gap, because channel presence updates on the next edge.
- CHANNEL_NUM=1:
  - sel is always 0 and rr_ptr stays 0.
  - Behaves as a 2-entry skid buffer.
- Reset asserted mid-operation: buffered tokens are dropped and all outputs return to reset values immediately (asynchronously). Upstream must re-issue.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> src_ready=1, ch_valid=0, dispatched_count=0, pending_cc_id=0 (all channels not present).
- Min-latency pick: CHANNEL_NUM=2, ch_latency={0:5, 1:3}, both ready, push pc=0x12 cc=1 -> next cycle ch_valid=2'b10, slice1 data=0x49, dispatched_count=1.
- Tie round-robin: both latencies 4, both ready, push 4 tokens back to back -> ch_valid sequence 01,10,01,10; rr_ptr alternates.
- Backpressure:
  - ch_ready=0, push 3 tokens -> src_ready drops after the 2nd push; 3rd held upstream; pending_cc_id reflects both buffered ids.
  - Raise ch_ready[0] -> both drain in order over 2 cycles.
- Simultaneous push/pop at count=1 with continuous traffic, 100 tokens -> count stays 1, order preserved, dispatched_count=100.
- Async reset mid-stream: assert rst=0 between edges with count=2 -> ch_valid and pending buffer bits clear immediately; after release, src_ready=1 and no stale token is dispatched.

Source files
------------

// File: rtl/channel_dispatcher.sv
// Write-side front end for a bank of multi-CC channels: a 2-entry skid buffer feeding
// whichever ready channel advertises the lowest wait, with round-robin tie-breaking.
module channel_dispatcher #(
  parameter int PC_WIDTH            = 8,
  parameter int CC_ID_BITS          = 2,
  parameter int LATENCY_COUNT_WIDTH = 10,
  parameter int CHANNEL_NUM         = 2,
  parameter int COUNT_WIDTH         = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            src_valid,
  input  logic [PC_WIDTH+CC_ID_BITS-1:0]                  src_data,
  output logic                                            src_ready,
  output logic [CHANNEL_NUM-1:0]                          ch_valid,
  output logic [CHANNEL_NUM*(PC_WIDTH+CC_ID_BITS)-1:0]    ch_data,
  input  logic [CHANNEL_NUM-1:0]                          ch_ready,
  input  logic [CHANNEL_NUM*LATENCY_COUNT_WIDTH-1:0]      ch_latency,
  input  logic [CHANNEL_NUM*(2**CC_ID_BITS)-1:0]          ch_present_cc_id,
  output logic [2**CC_ID_BITS-1:0]                        pending_cc_id,
  output logic [COUNT_WIDTH-1:0]                          dispatched_count
);

  localparam int TW    = PC_WIDTH + CC_ID_BITS;
  localparam int NCC   = 2**CC_ID_BITS;
  localparam int LW    = LATENCY_COUNT_WIDTH;
  localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  logic [TW-1:0]          r_head;
  logic [TW-1:0]          r_tail;
  logic [1:0]             r_count;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [COUNT_WIDTH-1:0] r_dispatched_count;

  logic [LW-1:0]          w_lat [CHANNEL_NUM];
  logic                   w_any;
  logic [PTR_W-1:0]       w_sel;
  logic [LW-1:0]          w_best;
  logic [PTR_W:0]         w_sum;
  logic [PTR_W-1:0]       w_idx;
  logic [PTR_W-1:0]       w_rr_next;
  logic                   w_push;
  logic                   w_pop;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_lat
    assign w_lat[g] = ch_latency[g*LW +: LW];
  end

  // Scan channels cyclically from rr_ptr; strict less-than keeps the first tied index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_any  = 1'b0;
    w_sel  = '0;
    w_best = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(CHANNEL_NUM))
        w_sum = w_sum - (PTR_W+1)'(CHANNEL_NUM);
      w_idx = w_sum[PTR_W-1:0];
      if (ch_ready[w_idx] && (r_count != 2'd0) && (!w_any || (w_lat[w_idx] < w_best))) begin
        w_any  = 1'b1;
        w_sel  = w_idx;
        w_best = w_lat[w_idx];
      end
    end
  end

  always_comb begin
    ch_valid = '0;
    if (w_any)
      ch_valid[w_sel] = 1'b1;
  end

  assign w_rr_next = (w_sel == PTR_W'(CHANNEL_NUM - 1)) ? '0 : w_sel + 1'b1;
  assign src_ready = (r_count != 2'd2);
  assign w_push    = src_valid && src_ready;
  assign w_pop     = w_any;
  assign ch_data   = {CHANNEL_NUM{r_head}};
  assign dispatched_count = r_dispatched_count;

  // A token being dispatched this cycle still shows as buffered; channel presence takes over next edge.
  always_comb begin
    pending_cc_id = '0;
    for (int i = 0; i < CHANNEL_NUM; i++)
      pending_cc_id = pending_cc_id | ch_present_cc_id[i*NCC +: NCC];
    if (r_count != 2'd0)
      pending_cc_id[r_head[CC_ID_BITS-1:0]] = 1'b1;
    if (r_count == 2'd2)
      pending_cc_id[r_tail[CC_ID_BITS-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two data entries are reset too; they are only two words and it keeps sim free of X.
      r_head             <= '0;
      r_tail             <= '0;
      r_count            <= 2'd0;
      r_rr_ptr           <= '0;
      r_dispatched_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= src_data;
          else                 r_tail <= src_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Push+pop only happens at count 1: the new token replaces the departing head.
        2'b11: r_head <= src_data;
        default: ;
      endcase
      if (w_pop)
        r_rr_ptr <= w_rr_next;
      if (w_pop && (r_dispatched_count != '1))
        r_dispatched_count <= r_dispatched_count + 1'b1;
    end
  end

endmodule
